// File: rtl/fetch_unit.sv
// Instruction fetch stage. It owns the PC and keeps at most one imem request in flight.
// Returned words go into a small {instr, pc} FIFO whose head is presented to decode.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | nothing outstanding
// S_WAIT | one request outstanding, its response will be buffered
// S_DROP | one request outstanding, its response will be discarded
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_w_i,
    input  logic        rst_w_i_l,
    output logic        imem_req_w_o_h,
    output logic [31:0] imem_addr_w_o,
    input  logic [31:0] imem_rdata_w_i,
    input  logic        imem_rvalid_w_i_h,
    input  logic        redirect_w_i_h,
    input  logic [31:0] redirect_pc_w_i,
    input  logic        stall_w_i_h,
    output logic        instr_valid_w_o_h,
    output logic [31:0] instr_w_o,
    output logic [31:0] instr_pc_w_o,
    output logic [6:0]  opcode_w_o
);

    localparam int             AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

    state_t        state, state_nxt;
    logic [31:0]   fetch_pc, fetch_pc_nxt, req_pc;
    logic [31:0]   fifo_instr [FIFO_DEPTH];
    logic [31:0]   fifo_pc    [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count, count_nxt;
    logic [31:0]   hold_instr, hold_pc;
    logic          push, pop, issue, head_valid;

    assign head_valid = (count != '0);

    always_comb begin
        pop          = head_valid && !stall_w_i_h;
        push         = (state == S_WAIT) && imem_rvalid_w_i_h && !redirect_w_i_h;
        count_nxt    = count + (AW+1)'(push) - (AW+1)'(pop);
        // Slot is only granted when the response is guaranteed a FIFO entry.
        issue        = rst_w_i_l && !redirect_w_i_h && (count_nxt < DEPTH_C) &&
                       ((state == S_IDLE) || ((state == S_WAIT) && imem_rvalid_w_i_h));
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        if (redirect_w_i_h) begin
            fetch_pc_nxt = redirect_pc_w_i & 32'hFFFF_FFFC;
            state_nxt    = ((state != S_IDLE) && !imem_rvalid_w_i_h) ? S_DROP : S_IDLE;
        end else if (issue) begin
            fetch_pc_nxt = fetch_pc + 32'd4;
            state_nxt    = S_WAIT;
        end else begin
            case (state)
                S_WAIT:  if (imem_rvalid_w_i_h) state_nxt = S_IDLE;
                S_DROP:  if (imem_rvalid_w_i_h) state_nxt = S_IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk_w_i or negedge rst_w_i_l) begin
        if (!rst_w_i_l) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            if (issue) req_pc <= fetch_pc;
        end
    end

    always_ff @(posedge clk_w_i or negedge rst_w_i_l) begin
        if (!rst_w_i_l) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            hold_instr <= '0;
            hold_pc    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
        end else begin
            // Remember the last presented head so outputs hold while empty.
            if (head_valid) begin
                hold_instr <= fifo_instr[rd_ptr];
                hold_pc    <= fifo_pc[rd_ptr];
            end
            if (redirect_w_i_h) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    fifo_instr[wr_ptr] <= imem_rdata_w_i;
                    fifo_pc[wr_ptr]    <= req_pc;
                    wr_ptr             <= wr_ptr + AW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                count <= count_nxt;
            end
        end
    end

    assign imem_req_w_o_h    = issue;
    assign imem_addr_w_o     = fetch_pc;
    assign instr_valid_w_o_h = head_valid;
    assign instr_w_o         = head_valid ? fifo_instr[rd_ptr] : hold_instr;
    assign instr_pc_w_o      = head_valid ? fifo_pc[rd_ptr]    : hold_pc;
    assign opcode_w_o        = instr_w_o[6:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable memory that returns the address
// as data, plus a second instance with RESET_PC at the top of the address space.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stale = 1'b0;
    int          mem_lat = 1;

    logic        req, rvalid, valid;
    logic [31:0] addr, rdata, instr, ipc;
    logic [6:0]  opcode;

    logic        req2, rvalid2, valid2;
    logic [31:0] addr2, rdata2, instr2, ipc2;
    logic [6:0]  opcode2;
    logic        zero_bit = 1'b0;
    logic [31:0] zero_word = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_unit u_dut (
        .clk_w_i           (clk),
        .rst_w_i_l         (rst_n),
        .imem_req_w_o_h    (req),
        .imem_addr_w_o     (addr),
        .imem_rdata_w_i    (rdata),
        .imem_rvalid_w_i_h (rvalid),
        .redirect_w_i_h    (redirect),
        .redirect_pc_w_i   (redirect_pc),
        .stall_w_i_h       (stall),
        .instr_valid_w_o_h (valid),
        .instr_w_o         (instr),
        .instr_pc_w_o      (ipc),
        .opcode_w_o        (opcode)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) u_dut_wrap (
        .clk_w_i           (clk),
        .rst_w_i_l         (rst_n),
        .imem_req_w_o_h    (req2),
        .imem_addr_w_o     (addr2),
        .imem_rdata_w_i    (rdata2),
        .imem_rvalid_w_i_h (rvalid2),
        .redirect_w_i_h    (zero_bit),
        .redirect_pc_w_i   (zero_word),
        .stall_w_i_h       (zero_bit),
        .instr_valid_w_o_h (valid2),
        .instr_w_o         (instr2),
        .instr_pc_w_o      (ipc2),
        .opcode_w_o        (opcode2)
    );

    // Memory for the main instance: one pending request, answered mem_lat cycles later.
    logic        pend;
    int          timer;
    logic [31:0] pend_addr;

    assign rvalid = (pend && timer == 1) || stale;
    assign rdata  = pend_addr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= 1'b0;
            timer     <= 0;
            pend_addr <= '0;
        end else if (req) begin
            pend      <= 1'b1;
            timer     <= mem_lat;
            pend_addr <= addr;
        end else if (rvalid) begin
            pend <= 1'b0;
        end else if (pend && timer > 1) begin
            timer <= timer - 1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid2 <= 1'b0;
            rdata2  <= '0;
        end else begin
            rvalid2 <= req2;
            rdata2  <= addr2;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic enter_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        stale    = 1'b0;
        #1;
    endtask

    // Returns at the sample point of cycle 0, the first cycle out of reset.
    task automatic leave_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic next_cyc();
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] e;

        // Power-on reset and streaming with a 1-cycle memory
        enter_reset();
        chk("rst_req", req, 0);
        chk("rst_valid", valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", ipc, 0);
        chk("rst_opcode", 32'(opcode), 0);
        mem_lat = 1;
        leave_reset();
        chk("t1_c0_req", req, 1);
        chk("t1_c0_addr", addr, 32'h0);
        chk("wrap_c0_addr", addr2, 32'hFFFF_FFFC);
        next_cyc();
        chk("t1_c1_req", req, 1);
        chk("t1_c1_addr", addr, 32'h4);
        chk("t1_c1_valid", valid, 0);
        chk("wrap_c1_req", req2, 1);
        chk("wrap_c1_addr", addr2, 32'h0);
        for (int k = 2; k <= 7; k++) begin
            next_cyc();
            e = 32'(4 * (k - 2));
            chk("t1_req", req, 1);
            chk("t1_addr", addr, 32'(4 * k));
            chk("t1_valid", valid, 1);
            chk("t1_instr", instr, e);
            chk("t1_pc", ipc, e);
            chk("t1_opcode", 32'(opcode), e & 32'h7F);
            if (k == 2) begin
                chk("wrap_head_pc", ipc2, 32'hFFFF_FFFC);
                chk("wrap_c2_addr", addr2, 32'h4);
            end
        end

        // Reset mid-stream, then a stale response in the first cycle out of reset
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_req", req, 0);
        chk("t6_rst_valid", valid, 0);
        chk("t6_rst_instr", instr, 0);
        chk("t6_rst_pc", ipc, 0);
        chk("t6_rst_opcode", 32'(opcode), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 1'b1;
        #1;
        chk("t6_c0_req", req, 1);
        chk("t6_c0_addr", addr, 32'h0);
        chk("t6_c0_valid", valid, 0);
        @(negedge clk);
        stale = 1'b0;
        #1;
        chk("t6_c1_valid", valid, 0);
        chk("t6_c1_addr", addr, 32'h4);
        next_cyc();
        chk("t6_c2_valid", valid, 1);
        chk("t6_c2_pc", ipc, 32'h0);

        // Stall with a 2-entry buffer
        enter_reset();
        stall = 1'b1;
        leave_reset();
        chk("t2_c0_req", req, 1);
        next_cyc();
        chk("t2_c1_addr", addr, 32'h4);
        for (int k = 2; k <= 5; k++) begin
            next_cyc();
            chk("t2_stall_req", req, 0);
            chk("t2_stall_valid", valid, 1);
            chk("t2_stall_pc", ipc, 32'h0);
        end
        @(negedge clk);
        stall = 1'b0;
        #1;
        chk("t2_c6_pc", ipc, 32'h0);
        chk("t2_c6_req", req, 1);
        chk("t2_c6_addr", addr, 32'h8);
        for (int k = 7; k <= 9; k++) begin
            next_cyc();
            chk("t2_drain_valid", valid, 1);
            chk("t2_drain_pc", ipc, 32'(4 * (k - 6)));
        end

        // Redirect while a 3-cycle request is outstanding
        enter_reset();
        mem_lat = 3;
        leave_reset();
        for (int k = 1; k <= 7; k++) begin
            next_cyc();
            chk("t3_req", req, (k == 3 || k == 6) ? 32'd1 : 32'd0);
        end
        chk("t3_c7_pc", ipc, 32'h4);
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        #1;
        chk("t3_r_req", req, 0);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        chk("t3_drop_req", req, 0);
        chk("t3_drop_valid", valid, 0);
        next_cyc();
        chk("t3_c10_req", req, 1);
        chk("t3_c10_addr", addr, 32'h100);
        chk("t3_c10_valid", valid, 0);
        for (int k = 11; k <= 12; k++) begin
            next_cyc();
            chk("t3_wait_req", req, 0);
            chk("t3_wait_valid", valid, 0);
        end
        next_cyc();
        chk("t3_c13_req", req, 1);
        chk("t3_c13_addr", addr, 32'h104);
        chk("t3_c13_valid", valid, 0);
        next_cyc();
        chk("t3_c14_valid", valid, 1);
        chk("t3_c14_pc", ipc, 32'h100);
        chk("t3_c14_instr", instr, 32'h100);

        // Redirect in the same cycle a response arrives
        enter_reset();
        mem_lat = 1;
        leave_reset();
        next_cyc();
        next_cyc();
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h203;
        #1;
        chk("t4_r_req", req, 0);
        chk("t4_r_valid", valid, 1);
        @(negedge clk);
        redirect = 1'b0;
        #1;
        chk("t4_c4_req", req, 1);
        chk("t4_c4_addr", addr, 32'h200);
        chk("t4_c4_valid", valid, 0);
        next_cyc();
        chk("t4_c5_valid", valid, 0);
        chk("t4_c5_addr", addr, 32'h204);
        next_cyc();
        chk("t4_c6_valid", valid, 1);
        chk("t4_c6_pc", ipc, 32'h200);
        chk("t4_c6_instr", instr, 32'h200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the CPE CPU. It holds the program counter, issues word fetches to instruction memory with at most one request outstanding, and buffers returned words in a small FIFO. The FIFO head is presented to the decode stage, which applies `opcode_w_o` directly to the control decoder's `opcode_w_i`. Branch and jump redirects flush the buffer and discard any in-flight response.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset; bits [1:0] must be 0.
- `FIFO_DEPTH`, default 2: instruction buffer entries; legal values 2 or 4.
- `clk_w_i`  input  1  clock; all state updates on the rising edge.
- `rst_w_i_l`  input  1  reset; asynchronous, active-low.
- `imem_req_w_o_h`  output  1  fetch request, valid for one cycle; memory always accepts it.
- `imem_addr_w_o`  output  32  fetch byte address, word aligned; meaningful when `imem_req_w_o_h` is high.
- `imem_rdata_w_i`  input  32  returned instruction word.
- `imem_rvalid_w_i_h`  input  1  response strobe; arrives at least 1 cycle after its request; responses are in order.
- `redirect_w_i_h`  input  1  taken branch, JAL or JALR; restart fetch at `redirect_pc_w_i`.
- `redirect_pc_w_i`  input  32  new PC; bits [1:0] are ignored and forced to 0.
- `stall_w_i_h`  input  1  decode cannot accept the head instruction this cycle.
- `instr_valid_w_o_h`  output  1  FIFO head is valid.
- `instr_w_o`  output  32  FIFO head instruction.
- `instr_pc_w_o`  output  32  PC of the FIFO head instruction.
- `opcode_w_o`  output  7  `instr_w_o[6:0]`.

## Operation
- Internal state:
  - `fetch_pc`, the next address to request.
  - FIFO of {instr, pc}, with read pointer, write pointer and count.
  - FSM with three states: IDLE (nothing outstanding), WAIT (one request outstanding, response kept), DROP (one request outstanding, response discarded).
- Pop: occurs when `instr_valid_w_o_h && !stall_w_i_h`.
- Push: occurs when `imem_rvalid_w_i_h` arrives in WAIT with no redirect in the same cycle. It writes {`imem_rdata_w_i`, PC of that request}.
- Issue: `imem_req_w_o_h` is combinational and is high when both of the following hold:
  - State is IDLE, or state is WAIT and `imem_rvalid_w_i_h` is high.
  - count after this cycle's push and pop is less than FIFO_DEPTH, and `redirect_w_i_h` is low.
- On issue: `imem_addr_w_o` = `fetch_pc`. `fetch_pc` advances by 4, with 32-bit wrap (32'hFFFF_FFFC wraps to 0). Next state is WAIT.
- WAIT with rvalid and no new issue → IDLE.
- Redirect has highest priority and acts in the cycle it is asserted:
  - FIFO is emptied; any pop that cycle is cancelled from decode's view.
  - `fetch_pc` = {`redirect_pc_w_i`[31:2], 2'b00}.
  - No request is issued that cycle.
  - If a request is outstanding and its response does not arrive this cycle → DROP; otherwise → IDLE.
- DROP: the response is discarded and the state goes to IDLE. Issue resumes from IDLE in the following cycle. A redirect in DROP only updates `fetch_pc` and stays in DROP.
- A response arriving in IDLE is a protocol violation and is ignored.
- Full FIFO: issue is suppressed, and the request slot is withheld until the FIFO has space for a response. Overflow cannot occur.
- Empty FIFO: `instr_valid_w_o_h` is 0; `instr_w_o`, `instr_pc_w_o` and `opcode_w_o` hold their last value.

## Timing
- Reset values (asynchronous on `rst_w_i_l` low):
  - `fetch_pc` = RESET_PC; state IDLE; FIFO empty.
  - `instr_valid_w_o_h` = 0, `instr_w_o` = 0, `instr_pc_w_o` = 0, `opcode_w_o` = 0.
  - `imem_req_w_o_h` = 0 while reset is asserted.
- First request: in the first cycle after `rst_w_i_l` deasserts, with `imem_addr_w_o` = RESET_PC.
- Latency: response in cycle n → `instr_valid_w_o_h` high in cycle n+1.
- Throughput: with a 1-cycle memory and no stall, one instruction per cycle. A request is issued in every cycle that carries a response.
- Redirect in cycle r:
  - `instr_valid_w_o_h` = 0 in cycle r+1.
  - From IDLE or a completed response, the new PC is requested in cycle r+1.
  - From DROP, the new PC is requested in the cycle after the discarded response.
- Reset asserted mid-operation: the outstanding request is abandoned. A response arriving after reset release, before the first new request, lands in IDLE and is ignored.

## Test plan
- Reset release with a 1-cycle memory returning addr as data, no stall:
  - requests go to 0x0, 0x4, 0x8… in consecutive cycles;
  - `instr_valid_w_o_h` is high from cycle 2;
  - `instr_pc_w_o` equals `instr_w_o`.
- Hold `stall_w_i_h`=1 with FIFO_DEPTH=2:
  - exactly 2 responses are buffered and requests stop;
  - the head stays at PC 0x0;
  - after releasing stall, the PCs 0x0, 0x4, 0x8 appear with none lost or duplicated.
- With a 3-cycle memory latency, assert redirect to 0x100 while a request to 0x8 is outstanding:
  - the 0x8 response is discarded;
  - `instr_valid_w_o_h` is 0 until the 0x100 response arrives;
  - the next request is 0x100, then 0x104.
- Redirect to 0x203 in the same cycle a response arrives:
  - the response is dropped;
  - the next request is 0x200 in cycle r+1.
- Set RESET_PC=32'hFFFF_FFFC:
  - the request sequence is 0xFFFF_FFFC, then 0x0000_0000.
- Assert `rst_w_i_l` low mid-stream and release it:
  - all outputs return to their reset values immediately;
  - the first new request is at RESET_PC;
  - a stale `imem_rvalid_w_i_h` pulse asserted while in IDLE, before that first request, produces no valid output.
